// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline buffer types, MEM-stage FSM states and load/store funct3 codes.
package mem_stage_ctrl_pkg;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  reg_wb_src;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc_plus_4;
    logic [31:0] ALU_result;
    logic [31:0] rd2;
    logic [31:0] tb_current_instr;
  } ex_mem_reg;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  reg_wb_src;
    logic [4:0]  rd;
    logic [31:0] pc_plus_4;
    logic [31:0] ALU_result;
    logic [31:0] mem_read_data;
    logic [31:0] tb_current_instr;
  } mem_wb_reg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        write,
  input  logic [1:0]  addr,
  input  logic [31:0] rd2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic        is_byte;
  logic        is_half;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Stores only know B and H; the unsigned codes fall through to word width.
    is_byte  = write ? (funct3 == F3_B) : (funct3 == F3_B || funct3 == F3_BU);
    is_half  = write ? (funct3 == F3_H) : (funct3 == F3_H || funct3 == F3_HU);
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = rdata[{addr[1], 4'b0000} +: 16];

    be         = 4'b1111;
    wdata      = rd2;
    load_data  = rdata;
    misaligned = 1'b0;

    if (is_byte) begin
      be        = 4'b0001 << addr;
      wdata     = {4{rd2[7:0]}};
      load_data = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      be         = 4'b0011 << {addr[1], 1'b0};
      wdata      = {2{rd2[15:0]}};
      load_data  = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      misaligned = addr[0];
    end else begin
      misaligned = (addr != 2'b00);
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: req/gnt/rvalid data-memory handshake, upstream stall and MEM/WB register.
//   state  | meaning
//   IDLE   | no access outstanding; non-memory ops and granted stores pass straight through
//   REQ    | request raised, waiting for gnt with addr/be/wdata held
//   WAIT_R | load granted, waiting for rvalid or timeout
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DMEM_AW      = 9,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  ex_mem_reg          ex_mem_i,
  input  logic               ex_valid_i,
  output logic               mem_stall_o,
  output mem_wb_reg          mem_wb_o,
  output logic               wb_valid_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [31:0]        dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [31:0]        dmem_rdata_i,
  output logic               misalign_o,
  output logic               timeout_o
);

  localparam int CW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  mem_state_e    state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          is_load, is_store, is_mem, misaligned;
  logic          req, stall, complete, load_done, misalign_hit, timeout_hit;
  logic          tmo_reached, wb_load;
  logic [31:0]   load_data;
  mem_wb_reg     wb_nxt;
  logic          unused_fields;

  assign is_load  = ex_mem_i.mem_read;
  assign is_store = ex_mem_i.mem_write & ~ex_mem_i.mem_read;
  assign is_mem   = ex_valid_i & (ex_mem_i.mem_read | ex_mem_i.mem_write);
  assign unused_fields = ^{ex_mem_i.branch, ex_mem_i.jump, ex_mem_i.rs2};

  mem_lane_align u_align (
    .funct3     (ex_mem_i.funct3),
    .write      (is_store),
    .addr       (ex_mem_i.ALU_result[1:0]),
    .rd2        (ex_mem_i.rd2),
    .rdata      (dmem_rdata_i),
    .be         (dmem_be_o),
    .wdata      (dmem_wdata_o),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign tmo_reached = (WAIT_TIMEOUT != 0) && (wait_cnt == CW'(WAIT_TIMEOUT - 1));

  always_comb begin
    state_nxt    = state;
    req          = 1'b0;
    stall        = 1'b0;
    complete     = 1'b0;
    load_done    = 1'b0;
    misalign_hit = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && misaligned) begin
          complete     = 1'b1;
          misalign_hit = 1'b1;
        end else if (is_mem) begin
          req = 1'b1;
          if (is_store && dmem_gnt_i) begin
            complete = 1'b1;
          end else begin
            stall     = 1'b1;
            state_nxt = (is_load && dmem_gnt_i) ? WAIT_R : REQ;
          end
        end else begin
          complete = ex_valid_i;
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem_gnt_i && is_store) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
          if (dmem_gnt_i) state_nxt = WAIT_R;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid_i) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_reached) begin
          complete    = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bubbles in IDLE still refresh the buffer so pass-through fields track EX/MEM.
  assign wb_load = complete | ((state == IDLE) & ~ex_valid_i);

  always_comb begin
    wb_nxt                  = '0;
    wb_nxt.reg_write        = ex_mem_i.reg_write & ~(misalign_hit | timeout_hit);
    wb_nxt.reg_wb_src       = ex_mem_i.reg_wb_src;
    wb_nxt.rd               = ex_mem_i.rd;
    wb_nxt.pc_plus_4        = ex_mem_i.pc_plus_4;
    wb_nxt.ALU_result       = ex_mem_i.ALU_result;
    wb_nxt.mem_read_data    = load_done ? load_data : 32'h0;
    wb_nxt.tb_current_instr = ex_mem_i.tb_current_instr;
  end

  assign dmem_req_o  = req & rst_n;
  assign dmem_we_o   = req & is_store & rst_n;
  assign mem_stall_o = stall & rst_n;
  assign dmem_addr_o = ex_mem_i.ALU_result[DMEM_AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      mem_wb_o   <= '0;
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      wait_cnt   <= (state == WAIT_R && state_nxt == WAIT_R) ? wait_cnt + 1'b1 : '0;
      wb_valid_o <= complete;
      misalign_o <= misalign_hit;
      timeout_o  <= timeout_hit;
      if (wb_load) mem_wb_o <= wb_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: expected writebacks queued at issue, checked on wb_valid_o.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam int DMEM_AW = 9;

  logic               clk = 1'b0;
  logic               rst_n;
  ex_mem_reg          ex_mem_i;
  logic               ex_valid_i;
  logic               mem_stall_o;
  mem_wb_reg          mem_wb_o;
  logic               wb_valid_o;
  logic               dmem_req_o;
  logic               dmem_we_o;
  logic [DMEM_AW-1:0] dmem_addr_o;
  logic [3:0]         dmem_be_o;
  logic [31:0]        dmem_wdata_o;
  logic               dmem_gnt_i;
  logic               dmem_rvalid_i;
  logic [31:0]        dmem_rdata_i;
  logic               misalign_o;
  logic               timeout_o;

  mem_stage_ctrl #(.DMEM_AW(DMEM_AW), .WAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_mem_i(ex_mem_i), .ex_valid_i(ex_valid_i),
    .mem_stall_o(mem_stall_o), .mem_wb_o(mem_wb_o), .wb_valid_o(wb_valid_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        reg_write;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic ex_mem_reg mk(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                   input logic [31:0] alu, input logic [31:0] rd2,
                                   input logic [4:0] rd, input logic rw);
    ex_mem_reg r;
    r                  = '0;
    r.mem_read         = rd_en;
    r.mem_write        = wr_en;
    r.funct3           = f3;
    r.ALU_result       = alu;
    r.rd2              = rd2;
    r.rd               = rd;
    r.reg_write        = rw;
    r.pc_plus_4        = alu + 32'd4;
    r.tb_current_instr = 32'h0000_0013;
    return r;
  endfunction

  task automatic push(input string tag, input logic rw, input logic [31:0] alu, input logic [4:0] rd,
                      input logic [31:0] d, input logic mis, input logic tmo);
    exp_t e;
    e.tag = tag; e.reg_write = rw; e.alu = alu; e.rd = rd; e.rdata = d; e.mis = mis; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    ex_valid_i    = 1'b0;
    ex_mem_i      = '0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'hDEAD_BEEF;
  endtask

  // Scoreboard: every writeback must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && wb_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", 32'(wb_valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, ".reg_write"}, 32'(mem_wb_o.reg_write), 32'(e.reg_write));
        chk({e.tag, ".alu"},       mem_wb_o.ALU_result,     e.alu);
        chk({e.tag, ".rd"},        32'(mem_wb_o.rd),        32'(e.rd));
        chk({e.tag, ".rdata"},     mem_wb_o.mem_read_data,  e.rdata);
        chk({e.tag, ".misalign"},  32'(misalign_o),         32'(e.mis));
        chk({e.tag, ".timeout"},   32'(timeout_o),          32'(e.tmo));
      end
    end
  end

  // gnt_at/rv_at are cycle offsets from issue; -1 means never.
  task automatic load_seq(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input int gnt_at, input int rv_at,
                          input int exp_stalls, input logic [31:0] exp_data, input logic tmo);
    int   stalls = 0;
    logic done   = 1'b0;
    ex_mem_i   = mk(1'b1, 1'b0, f3, addr, 32'h0, 5'd7, 1'b1);
    ex_valid_i = 1'b1;
    push(tag, ~tmo, addr, 5'd7, tmo ? 32'h0 : exp_data, 1'b0, tmo);
    for (int c = 0; c < 20 && !done; c++) begin
      dmem_gnt_i    = (c == gnt_at);
      dmem_rvalid_i = (c == rv_at);
      dmem_rdata_i  = (c == rv_at) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (c == 0) begin
        chk({tag, ".req_issue"}, 32'(dmem_req_o), 32'd1);
        chk({tag, ".addr"}, 32'(dmem_addr_o), {23'b0, addr[DMEM_AW+1:2]});
      end
      if (c == gnt_at + 1) chk({tag, ".req_in_wait"}, 32'(dmem_req_o), 32'd0);
      if (mem_stall_o === 1'b1) begin
        stalls++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    step();
    bubble();
    @(negedge clk);
    chk({tag, ".wb_valid"}, 32'(wb_valid_o), 32'd1);
    chk({tag, ".timeout_pulse"}, 32'(timeout_o), 32'(tmo));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    bubble();

    @(negedge clk);
    chk("rst.stall",     32'(mem_stall_o), 32'd0);
    chk("rst.req",       32'(dmem_req_o),  32'd0);
    chk("rst.wb_valid",  32'(wb_valid_o),  32'd0);
    chk("rst.mem_wb",    32'(|mem_wb_o),   32'd0);
    chk("rst.misalign",  32'(misalign_o),  32'd0);
    chk("rst.timeout",   32'(timeout_o),   32'd0);
    step();
    rst_n = 1'b1;

    // Non-memory op passes through in one cycle.
    ex_mem_i   = mk(1'b0, 1'b0, F3_W, 32'h1234, 32'h0, 5'd5, 1'b1);
    ex_valid_i = 1'b1;
    push("alu", 1'b1, 32'h1234, 5'd5, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("alu.stall", 32'(mem_stall_o), 32'd0);
    chk("alu.req",   32'(dmem_req_o),  32'd0);
    step();
    bubble();
    @(negedge clk);
    chk("alu.wb_valid", 32'(wb_valid_o), 32'd1);
    step();
    @(negedge clk);
    chk("bubble.wb_valid", 32'(wb_valid_o), 32'd0);
    step();

    // SB to lane 3 with immediate grant.
    ex_mem_i   = mk(1'b0, 1'b1, F3_B, 32'h103, 32'h0000_00AB, 5'd0, 1'b0);
    ex_valid_i = 1'b1;
    dmem_gnt_i = 1'b1;
    push("sb", 1'b0, 32'h103, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sb.req",   32'(dmem_req_o),  32'd1);
    chk("sb.we",    32'(dmem_we_o),   32'd1);
    chk("sb.be",    32'(dmem_be_o),   32'h8);
    chk("sb.wdata", dmem_wdata_o,     32'hABAB_ABAB);
    chk("sb.addr",  32'(dmem_addr_o), 32'h40);
    chk("sb.stall", 32'(mem_stall_o), 32'd0);
    step();
    bubble();
    @(negedge clk);
    chk("sb.wb_valid", 32'(wb_valid_o), 32'd1);
    step();

    // SH to upper half; grant one cycle late so the request is held in REQ.
    ex_mem_i   = mk(1'b0, 1'b1, F3_H, 32'h22, 32'h1234_BEEF, 5'd0, 1'b0);
    ex_valid_i = 1'b1;
    push("sh", 1'b0, 32'h22, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sh.stall_req", 32'(mem_stall_o), 32'd1);
    step();
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("sh.be",    32'(dmem_be_o),   32'hC);
    chk("sh.wdata", dmem_wdata_o,     32'hBEEF_BEEF);
    chk("sh.we",    32'(dmem_we_o),   32'd1);
    chk("sh.stall_gnt", 32'(mem_stall_o), 32'd0);
    step();
    bubble();
    step();

    // LB / LBU: gnt at +2, rvalid at +5, five stall cycles.
    load_seq("lb",  F3_B,  32'h2, 32'h0080_FF00, 2, 5, 5, 32'hFFFF_FF80, 1'b0);
    load_seq("lbu", F3_BU, 32'h2, 32'h0080_FF00, 2, 5, 5, 32'h0000_0080, 1'b0);
    load_seq("lh",  F3_H,  32'h6, 32'h8001_7FFF, 0, 1, 1, 32'hFFFF_8001, 1'b0);

    // Misaligned LW is dropped without a request.
    ex_mem_i   = mk(1'b1, 1'b0, F3_W, 32'h6, 32'h0, 5'd9, 1'b1);
    ex_valid_i = 1'b1;
    push("lw_mis", 1'b0, 32'h6, 5'd9, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lw_mis.req",   32'(dmem_req_o),  32'd0);
    chk("lw_mis.stall", 32'(mem_stall_o), 32'd0);
    step();
    bubble();
    @(negedge clk);
    chk("lw_mis.pulse", 32'(misalign_o), 32'd1);
    step();
    @(negedge clk);
    chk("lw_mis.pulse_end", 32'(misalign_o), 32'd0);
    step();

    // LW timeout: granted immediately, rvalid never arrives; 4 WAIT_R cycles.
    load_seq("lw_tmo", F3_W, 32'h8, 32'h0, 0, -1, 4, 32'h0, 1'b1);
    @(negedge clk);
    chk("lw_tmo.idle_stall", 32'(mem_stall_o), 32'd0);
    step();

    // Reset while waiting for read data; the load stays presented on ex_mem_i.
    a          = 32'hC;
    ex_mem_i   = mk(1'b1, 1'b0, F3_W, a, 32'h0, 5'd3, 1'b1);
    ex_valid_i = 1'b1;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wait.req",      32'(dmem_req_o),  32'd0);
    chk("rst_wait.stall",    32'(mem_stall_o), 32'd0);
    chk("rst_wait.wb_valid", 32'(wb_valid_o),  32'd0);
    step();
    bubble();
    #2;
    rst_n = 1'b1;
    step();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h5555_AAAA;
    step();
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("rst_wait.late_rvalid", 32'(wb_valid_o), 32'd0);
    step();
    step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller for the 5-stage RISC-V pipeline.
- Consumes the EX/MEM buffer (ex_mem_reg) and produces the MEM/WB buffer (mem_wb_reg).
- Runs a req/gnt/rvalid handshake to a variable-latency data memory.
- Does byte-lane alignment for loads and stores, and stalls upstream stages while an access is outstanding.

Parameters:
- DMEM_AW, 9: data-memory word-address width; dmem_addr_o = ALU_result[DMEM_AW+1:2].
- WAIT_TIMEOUT, 255: maximum cycles in WAIT_R before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_mem_i  in  ex_mem_reg (148)  EX/MEM buffer contents; held stable by upstream while mem_stall_o=1
- ex_valid_i  in  1  ex_mem_i carries a real instruction (0 = bubble)
- mem_stall_o  out  1  freeze PC/IF/ID/EX and their buffers
- mem_wb_o  out  mem_wb_reg (136)  registered MEM/WB buffer
- wb_valid_o  out  1  mem_wb_o holds a real instruction
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  DMEM_AW  word address
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read word
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- timeout_o  out  1  one-cycle pulse: read aborted on timeout

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE, wait counter to 0.
  - mem_wb_o=0, wb_valid_o=0, misalign_o=0, timeout_o=0.
  - mem_stall_o, dmem_req_o and dmem_we_o forced to 0 while rst_n is low.
  - Reset mid-access abandons the access; no writeback occurs.
- Op decode:
  - mem_read has priority if both mem_read and mem_write are set.
  - A non-memory op is ex_valid_i=1 with both mem_read and mem_write at 0.
- Non-memory op or bubble in IDLE:
  - mem_wb_o loads pass-through fields (reg_write, reg_wb_src, pc_plus_4, ALU_result, rd, tb_current_instr) on the next edge.
  - mem_read_data=0; wb_valid_o=ex_valid_i; latency 1; no stall.
- FSM states IDLE, REQ, WAIT_R:
  - IDLE, valid aligned access: dmem_req_o=1 combinationally from ex_mem_i.
    - Store with gnt: complete, writeback next edge, stall=0.
    - Store without gnt: go to REQ, stall=1.
    - Load with gnt: go to WAIT_R, stall=1.
    - Load without gnt: go to REQ, stall=1.
  - REQ: dmem_req_o=1 and stall=1 until gnt.
    - On gnt, a store completes (stall=0 that cycle, back to IDLE).
    - On gnt, a load goes to WAIT_R.
  - WAIT_R: dmem_req_o=0.
    - On dmem_rvalid_i: mem_read_data is the extracted value and loads on that edge; stall=0 that cycle; return to IDLE.
    - Counter increments each WAIT_R cycle. When it reaches WAIT_TIMEOUT with no rvalid, complete with reg_write=0, pulse timeout_o, and return to IDLE.
- Requests held in REQ keep addr, be, wdata and we stable until gnt.
- wb_valid_o=0 on every edge where the instruction does not complete.
- rvalid in the same cycle as gnt is not allowed; the memory returns data at least 1 cycle after gnt.
- Loads, with lane = addr[1:0]:
  - LB (000) / LBU (100): byte at lane, sign-extended / zero-extended.
  - LH (001) / LHU (101): half at addr[1], sign-extended / zero-extended.
  - LW (010) and all other funct3 values: full word.
- Stores:
  - SB: be = 0001<<lane, wdata = {4{rd2[7:0]}}.
  - SH: be = 0011<<(2*addr[1]), wdata = {2{rd2[15:0]}}.
  - SW and all other funct3 values: be = 1111.
- Misalignment (half with addr[0]=1, word with addr[1:0]!=0):
  - No request is issued and there is no stall.
  - Writeback next edge with reg_write=0 and wb_valid_o=1.
  - misalign_o pulses in that same cycle.

Decomposition:
- Shared package (alongside the existing ex_mem_reg/mem_wb_reg typedefs) gains:
  - mem_state_e enum {IDLE, REQ, WAIT_R}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One natural sub-module: mem_lane_align (combinational).
  - Inputs: funct3, addr[1:0], rd2, rdata.
  - Outputs: be, wdata, load data, misaligned.

Test Plan:
- Non-memory op, ALU_result=0x1234, rd=5, reg_write=1 -> next cycle mem_wb_o.ALU_result=0x1234, rd=5, wb_valid_o=1, mem_stall_o never high.
- SB, addr=0x103, rd2=0xAB, gnt same cycle -> dmem_be_o=1000, dmem_wdata_o=0xABABABAB, dmem_addr_o=0x40, stall=0, wb_valid_o=1 next cycle.
- LB, addr=0x2, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x0080FF00:
  - stall high for 5 cycles.
  - mem_read_data=0xFFFFFF80.
  - The same sequence with LBU gives 0x00000080.
- LW, addr=0x6 -> no dmem_req_o, misalign_o pulse, mem_wb_o.reg_write=0, wb_valid_o=1.
- LW with WAIT_TIMEOUT=4 and rvalid never asserted -> after 4 WAIT_R cycles timeout_o pulses, reg_write=0, stall drops, state IDLE.
- rst_n low during WAIT_R -> dmem_req_o, mem_stall_o and wb_valid_o are 0 immediately; after release, a late rvalid is ignored (no wb_valid_o).
